// File: rtl/shared_adder_arbiter_pkg.sv
// Shared types and constants for the shared adder arbiter: output-register states and operand payload.
package shared_adder_arbiter_pkg;

    localparam int unsigned SA_MAX_REQ = 8;
    localparam int unsigned SA_WIDTH   = 32;

    typedef enum logic {
        SA_EMPTY = 1'b0,
        SA_FULL  = 1'b1
    } sa_state_e;

    typedef struct packed {
        logic [SA_WIDTH-1:0] a;
        logic [SA_WIDTH-1:0] b;
    } sa_operands_t;

endpackage

// File: rtl/CLA32BitNoCarry.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead blocks; carry-out is not produced.
module CLA32BitNoCarry (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gc;

    assign g     = a_i & b_i;
    assign p     = a_i ^ b_i;
    assign gc[0] = 1'b0;

    for (genvar blk = 0; blk < 8; blk++) begin : g_blk
        localparam int unsigned B = 4 * blk;
        logic [3:0] c;

        assign c[0] = gc[blk];
        assign c[1] = g[B] | (p[B] & c[0]);
        assign c[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[0]);
        assign c[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & c[0]);
        assign sum_o[B +: 4] = p[B +: 4] ^ c;

        // Block carry into the next nibble; the top block's carry-out is discarded.
        if (blk < 7) begin : g_cout
            assign gc[blk+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B])
                             | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[0]);
        end
    end

endmodule

// File: rtl/shared_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter with optional fixed priority for requester 0; owns the rotating pointer.
module shared_adder_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic               prio0,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    gidx
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] gptr;
    logic             found;

    // First valid requester at or after ptr; requester 0 is pulled out of the ring when prio0 is set.
    always_comb begin
        grant = '0;
        gidx  = '0;
        gptr  = '0;
        found = 1'b0;
        if (prio0 && req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            automatic logic [PTR_W-1:0] idx = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
            if (!found && req[idx] && !(prio0 && (idx == '0))) begin
                grant[idx] = 1'b1;
                gidx       = ID_W'(idx);
                gptr       = idx;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found && !(prio0 && grant[0])) begin
            ptr_d = (gptr == PTR_W'(NUM_REQ - 1)) ? '0 : gptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_adder_arbiter.sv
// Shares one 32-bit adder among NUM_REQ requesters with a 1-entry result register.
// SHARED_ADDER_PRIO_EN: requester 0 gets fixed top priority, the rest stay round-robin.
module shared_adder_arbiter
    import shared_adder_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum
);

    if (WIDTH != SA_WIDTH) begin : g_bad_width
        $error("shared_adder_arbiter: only WIDTH=32 is supported");
    end
    if (NUM_REQ < 2 || NUM_REQ > SA_MAX_REQ) begin : g_bad_num_req
        $error("shared_adder_arbiter: NUM_REQ must be 2..8");
    end
    if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("shared_adder_arbiter: ID_W too narrow for NUM_REQ");
    end

`ifdef SHARED_ADDER_PRIO_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    sa_state_e        state_q;
    sa_state_e        state_d;
    logic [ID_W-1:0]  rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;

    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    gidx_c;
    logic               accept_c;
    logic               load_c;
    sa_operands_t       ops_c;
    logic [WIDTH-1:0]   sum_c;

    shared_adder_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (load_c),
        .prio0   (PRIO0),
        .grant   (grant_c),
        .gidx    (gidx_c)
    );

    // AND-OR operand mux over the one-hot grant.
    always_comb begin
        ops_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ops_c.a = ops_c.a | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_c[i]}});
            ops_c.b = ops_c.b | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_c[i]}});
        end
    end

    CLA32BitNoCarry u_adder (
        .a_i   (ops_c.a),
        .b_i   (ops_c.b),
        .sum_o (sum_c)
    );

    // A new result may enter when the register is empty or is being drained this cycle.
    always_comb begin
        state_d   = state_q;
        accept_c  = (state_q == SA_EMPTY) || rsp_ready;
        load_c    = accept_c && (|req_valid);
        req_ready = (rst && accept_c) ? grant_c : '0;
        if (load_c) begin
            state_d = SA_FULL;
        end else if (state_q == SA_FULL && rsp_ready) begin
            state_d = SA_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SA_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_id_q  <= '0;
            rsp_sum_q <= '0;
        end else if (load_c) begin
            rsp_id_q  <= gidx_c;
            rsp_sum_q <= sum_c;
        end
    end

    assign rsp_valid = (state_q == SA_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter (NUM_REQ=2); expectations follow SHARED_ADDER_PRIO_EN when defined.
module tb_shared_adder_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    shared_adder_arbiter #(
        .NUM_REQ (2),
        .WIDTH   (32),
        .ID_W    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Advance one edge, then observe at the following falling edge.
    task automatic edge_then_sample();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    logic [0:0]  fair_id  [6];
    logic [31:0] fair_sum [6];
    logic [0:0]  last_id;
    logic [31:0] last_sum;

    initial begin
`ifdef SHARED_ADDER_PRIO_EN
        for (int k = 0; k < 6; k++) begin
            fair_id[k]  = 1'b0;
            fair_sum[k] = 32'h11;
        end
`else
        for (int k = 0; k < 6; k++) begin
            fair_id[k]  = 1'(k % 2);
            fair_sum[k] = (k % 2 == 0) ? 32'h11 : 32'h22;
        end
`endif

        rst       = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        set_ops(0, 32'h0000_0100, 32'h0000_0004);
        set_ops(1, 32'hFFFF_FFFF, 32'h0000_0001);

        // Reset holds everything quiet even with requests pending
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_rsp_id",    32'(rsp_id),    32'h0);
        check_eq("rst_rsp_sum",   rsp_sum,        32'h0);

        rst = 1'b1;
        #1;
        check_eq("first_grant_req0", 32'(req_ready), 32'h1);

        // Single request from req0
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("single_valid", 32'(rsp_valid), 32'h1);
        check_eq("single_id",    32'(rsp_id),    32'h0);
        check_eq("single_sum",   rsp_sum,        32'h0000_0104);
        check_eq("full_stall_ready", 32'(req_ready), 32'h0);

        rsp_ready = 1'b1;
        edge_then_sample();
        check_eq("drain_empty", 32'(rsp_valid), 32'h0);

        // Wrap-around sums
        req_valid = 2'b10;
        #1;
        check_eq("wrap_grant_req1", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("wrap1_valid", 32'(rsp_valid), 32'h1);
        check_eq("wrap1_id",    32'(rsp_id),    32'h1);
        check_eq("wrap1_sum",   rsp_sum,        32'h0);

        @(posedge clk);
        #1;
        set_ops(0, 32'h8000_0000, 32'h8000_0000);
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("wrap2_id",  32'(rsp_id), 32'h0);
        check_eq("wrap2_sum", rsp_sum,     32'h0);

        @(posedge clk);
        #1;
        set_ops(1, 32'h1234_5678, 32'h1111_1111);
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("plain_id",  32'(rsp_id), 32'h1);
        check_eq("plain_sum", rsp_sum,     32'h2345_6789);

        // Fairness with both requesters continuously valid
        @(posedge clk);
        #1;
        set_ops(0, 32'h0000_0010, 32'h0000_0001);
        set_ops(1, 32'h0000_0020, 32'h0000_0002);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            edge_then_sample();
            check_eq($sformatf("fair_id_%0d", k),  32'(rsp_id), 32'(fair_id[k]));
            check_eq($sformatf("fair_sum_%0d", k), rsp_sum,     fair_sum[k]);
        end
        last_id  = fair_id[5];
        last_sum = fair_sum[5];

        // Backpressure: result held, nothing accepted
        rsp_ready = 1'b0;
        #1;
        check_eq("bp_ready_0", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            edge_then_sample();
            check_eq($sformatf("bp_ready_c%0d", k), 32'(req_ready), 32'h0);
            check_eq($sformatf("bp_valid_c%0d", k), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("bp_id_c%0d", k),    32'(rsp_id),    32'(last_id));
            check_eq($sformatf("bp_sum_c%0d", k),   rsp_sum,        last_sum);
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_grant", 32'(req_ready), 32'h1);
        edge_then_sample();
        check_eq("passthru_valid", 32'(rsp_valid), 32'h1);
        check_eq("passthru_id",    32'(rsp_id),    32'h0);
        check_eq("passthru_sum",   rsp_sum,        32'h11);

        // Asynchronous reset while FULL
        rsp_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rsp_valid), 32'h0);
        check_eq("midrst_id",    32'(rsp_id),    32'h0);
        check_eq("midrst_sum",   rsp_sum,        32'h0);
        check_eq("midrst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_ptr0_grant", 32'(req_ready), 32'h1);
        edge_then_sample();
        check_eq("postrst_id",  32'(rsp_id), 32'h0);
        check_eq("postrst_sum", rsp_sum,     32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
